riscy_data_mem_responder: RTL and testbench

Synthesizable responder for the RISCY core's data memory port: answers the core's req/gnt/rvalid transactions with a single-port word memory, configurable response latency and injectable grant stalls. It sits on the memory side of the core-facing data bus, opposite the core's `data_*_o` outputs, so that benches and FPGA builds share one memory model instead of driving `data_rdata_i` and `data_gnt_i` by hand.

---
 rtl/riscy_data_mem_responder_pkg.sv | 34 +++
 rtl/riscy_data_mem_responder_resp_pipe.sv | 56 +++++
 rtl/riscy_data_mem_responder.sv | 91 +++++++++
 tb/tb_riscy_data_mem_responder.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscy_data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscy_mem_pkg
// Purpose  : Shared types and helpers for the RISCY data memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package riscy_mem_pkg;

    localparam int WORD_BYTES = 4;

    // One response beat travelling down the latency pipe
    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } mem_resp_t;

    // Replace only the bytes of old_word whose enable bit is set
    function automatic logic [31:0] be_merge(
        input logic [31:0]           old_word,
        input logic [31:0]           new_word,
        input logic [WORD_BYTES-1:0] be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscy_data_mem_responder_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : riscy_resp_pipe
// Purpose  : LATENCY-stage shift register carrying valid + response payload.
//            Reset clears only the valid bits; payload needs no reset because
//            it is never observed without its valid.
// Revision : 1.0 - initial release
// ============================================================================
module riscy_resp_pipe
    import riscy_mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      i_valid,
    input  mem_resp_t i_resp,
    output logic      o_valid,
    output mem_resp_t o_resp
);

    logic [LATENCY-1:0] r_valid;
    mem_resp_t          r_resp  [LATENCY];
    logic [LATENCY-1:0] w_valid_in;
    mem_resp_t          w_resp_in [LATENCY];

    // Stage 0 is fed from the grant; every later stage from its predecessor
    assign w_valid_in[0] = i_valid;
    assign w_resp_in[0]  = i_resp;

    for (genvar g = 1; g < LATENCY; g++) begin : g_link
        assign w_valid_in[g] = r_valid[g-1];
        assign w_resp_in[g]  = r_resp[g-1];
    end

    // Valid bits: dropped on reset so in-flight responses are never delivered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= '0;
        end else begin
            r_valid <= w_valid_in;
        end
    end

    // Payload shift, unreset
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < LATENCY; i++) begin
            r_resp[i] <= w_resp_in[i];
        end
    end

    assign o_valid = r_valid[LATENCY-1];
    assign o_resp  = r_resp[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/riscy_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : riscy_data_mem_responder
// Purpose  : Memory-side responder for the RISCY data port (req/gnt/rvalid):
//            single-port word memory, fixed response latency, outstanding
//            limit and an injectable grant stall.
// Revision : 1.0 - initial release
// ============================================================================
module riscy_data_mem_responder
    import riscy_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS     = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    input  logic        stall_i
);

    localparam int unsigned c_idx_w = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [32:0]        w_offset;
    logic               w_in_range;
    logic [c_idx_w-1:0] w_idx;
    logic               w_gnt;
    logic               w_pipe_valid;
    mem_resp_t          w_pipe_resp;
    mem_resp_t          w_resp_in;
    logic [3:0]         r_count;
    logic [31:0]        r_mem [DEPTH_WORDS];

    // 33-bit subtraction: bit 32 is the borrow, i.e. the address lies below the base
    assign w_offset   = {1'b0, data_addr_i} - {1'b0, BASE_ADDR};
    assign w_in_range = !w_offset[32] && ({2'b00, w_offset[31:2]} < DEPTH_WORDS);
    assign w_idx      = w_offset[c_idx_w+1:2];

    // An rvalid in this cycle frees a slot, so a full counter can still grant
    assign w_gnt = data_req_i && !stall_i && !rst_i &&
                   ((r_count < 4'(MAX_OUTSTANDING)) || w_pipe_valid);

    // Reads sample the pre-write word; writes and errors answer with zero data
    assign w_resp_in.err   = !w_in_range;
    assign w_resp_in.rdata = (w_in_range && !data_we_i) ? r_mem[w_idx] : 32'h0;

    // Byte-enabled write at grant; contents survive reset
    always_ff @(posedge clk_i) begin
        if (w_gnt && data_we_i && w_in_range) begin
            r_mem[w_idx] <= be_merge(r_mem[w_idx], data_wdata_i, data_be_i);
        end
    end

    // Outstanding count: +1 per grant, -1 per response, held when both coincide
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_count <= '0;
        end else if (w_gnt && !w_pipe_valid) begin
            r_count <= r_count + 4'd1;
        end else if (!w_gnt && w_pipe_valid) begin
            r_count <= r_count - 4'd1;
        end
    end

    riscy_resp_pipe #(
        .LATENCY (int'(LATENCY))
    ) u_resp_pipe (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_valid (w_gnt),
        .i_resp  (w_resp_in),
        .o_valid (w_pipe_valid),
        .o_resp  (w_pipe_resp)
    );

    assign data_gnt_o    = w_gnt;
    assign data_rvalid_o = w_pipe_valid;
    assign data_rdata_o  = w_pipe_valid ? w_pipe_resp.rdata : 32'h0;
    assign data_err_o    = w_pipe_valid && w_pipe_resp.err;

endmodule
`default_nettype wire

// File: tb/tb_riscy_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscy_data_mem_responder
// Purpose  : Self-checking bench for riscy_data_mem_responder. Three instances
//            with different latency/base/depth share one clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscy_data_mem_responder;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req    [N];
    logic        we     [N];
    logic        stall  [N];
    logic        gnt    [N];
    logic        rvalid [N];
    logic        err    [N];
    logic [3:0]  be     [N];
    logic [31:0] addr   [N];
    logic [31:0] wdata  [N];
    logic [31:0] rdata  [N];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        riscy_data_mem_responder #(
            .DEPTH_WORDS     ((g == 2) ? 256 : 1024),
            .BASE_ADDR       ((g == 2) ? 32'h0000_1000 : 32'h0000_0000),
            .LATENCY         ((g == 0) ? 1 : ((g == 1) ? 3 : 4)),
            .MAX_OUTSTANDING (2)
        ) u_dut (
            .clk_i         (clk),
            .rst_i         (rst),
            .data_req_i    (req[g]),
            .data_gnt_o    (gnt[g]),
            .data_we_i     (we[g]),
            .data_be_i     (be[g]),
            .data_addr_i   (addr[g]),
            .data_wdata_i  (wdata[g]),
            .data_rvalid_o (rvalid[g]),
            .data_rdata_o  (rdata[g]),
            .data_err_o    (err[g]),
            .stall_i       (stall[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction
    function automatic logic [31:0] base_of(input int k);
        return (k == 2) ? 32'h0000_1000 : 32'h0000_0000;
    endfunction
    function automatic int depth_of(input int k);
        return (k == 2) ? 256 : 1024;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One transaction; called just after a rising edge, returns just after one
    task automatic txn(input int k, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic e, output logic [31:0] r);
        int n;
        lat = -1; e = 1'bx; r = 'x;
        req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
        @(negedge clk);
        n = 0;
        while (!gnt[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (gnt[k]) begin
            @(posedge clk); #1;
            req[k] = 1'b0;
            n = 1;
            @(negedge clk);
            while (!rvalid[k] && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (rvalid[k]) begin
                lat = n; e = err[k]; r = rdata[k];
            end
        end else begin
            req[k] = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    // Random traffic against a queue/array reference model
    task automatic rand_run(input int k, input int ncyc);
        exp_t          q[$];
        exp_t          e;
        logic [31:0]   mref [int];
        int            pool [8];
        bit            pending;
        int            ninit;
        logic          exp_rv;
        logic          exp_g;
        longint        off;
        int            idx;
        logic [31:0]   base;
        logic [31:0]   w;
        int            dep;
        base = base_of(k);
        dep  = depth_of(k);
        pool = '{0, 1, 2, 3, 5, 7, dep - 2, dep - 1};
        pending = 1'b0;
        ninit = 0;
        for (int cyc = 0; cyc < ncyc + 20; cyc++) begin
            if (!pending && cyc < ncyc) begin
                if (ninit < 8) begin
                    we[k] = 1'b1; be[k] = 4'hF; wdata[k] = $urandom;
                    addr[k] = base + 32'(4 * pool[ninit]);
                    ninit++;
                    pending = 1'b1;
                end else if ($urandom_range(0, 9) < 7) begin
                    we[k]    = 1'($urandom_range(0, 1));
                    be[k]    = 4'($urandom_range(0, 15));
                    wdata[k] = $urandom;
                    case ($urandom_range(0, 9))
                        0:       addr[k] = base + 32'(4 * dep) + 32'($urandom_range(0, 3));
                        1:       addr[k] = base - 32'd4;
                        2:       addr[k] = 32'hFFFF_FFF0;
                        default: addr[k] = base + 32'(4 * pool[$urandom_range(0, 7)])
                                                + 32'($urandom_range(0, 3));
                    endcase
                    pending = 1'b1;
                end
            end
            req[k]   = pending;
            stall[k] = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            exp_rv = (q.size() > 0) && (q[0].due == cyc);
            exp_g  = pending && !stall[k] && (q.size() < 2 || exp_rv);
            chk($sformatf("rand%0d gnt c%0d", k, cyc), 32'(gnt[k]), 32'(exp_g));
            chk($sformatf("rand%0d rvalid c%0d", k, cyc), 32'(rvalid[k]), 32'(exp_rv));
            if (exp_rv) begin
                e = q.pop_front();
                if (rvalid[k]) begin
                    chk($sformatf("rand%0d err c%0d", k, cyc), 32'(err[k]), 32'(e.err));
                    chk($sformatf("rand%0d rdata c%0d", k, cyc), rdata[k], e.rdata);
                end
            end
            if (exp_g) begin
                off = longint'({32'b0, addr[k]}) - longint'({32'b0, base});
                e.due = cyc + lat_of(k);
                e.err = 1'b1;
                e.rdata = 32'h0;
                if (off >= 0 && off < longint'(4 * dep)) begin
                    idx = int'(off / 4) + k * 65536;
                    e.err = 1'b0;
                    if (we[k]) begin
                        w = mref.exists(idx) ? mref[idx] : 32'h0;
                        for (int b = 0; b < 4; b++) begin
                            if (be[k][b]) w[8*b +: 8] = wdata[k][8*b +: 8];
                        end
                        mref[idx] = w;
                    end else begin
                        e.rdata = mref[idx];
                    end
                end
                q.push_back(e);
                pending = 1'b0;
            end
            @(posedge clk); #1;
        end
        req[k] = 1'b0; stall[k] = 1'b0;
        chk($sformatf("rand%0d drained", k), 32'(q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [16];
        int          lat;
        logic        e;
        logic [31:0] r;
        int          grants;
        int          rvs;
        int          rx;
        int          nidx;
        int          first_rv;
        int          pat [6];
        logic        exp_g;
        logic        prev_g;

        vecs = '{
            '{1'b1, 4'hF, 32'h0000_0000, 32'h0102_0304, 1'b0, 32'h0},
            '{1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0},
            '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF},
            '{1'b1, 4'h2, 32'h0000_0010, 32'h0000_5500, 1'b0, 32'h0},
            '{1'b0, 4'hF, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_55EF},
            '{1'b1, 4'hF, 32'h0000_1000, 32'h1234_5678, 1'b1, 32'h0},
            '{1'b0, 4'hF, 32'h0000_1000, 32'h0,         1'b1, 32'h0},
            '{1'b0, 4'hF, 32'h0000_0000, 32'h0,         1'b0, 32'h0102_0304},
            '{1'b1, 4'h8, 32'h0000_0013, 32'hAA00_0000, 1'b0, 32'h0},
            '{1'b0, 4'hF, 32'h0000_0011, 32'h0,         1'b0, 32'hAAAD_55EF},
            '{1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 1'b0, 32'h0},
            '{1'b1, 4'h0, 32'h0000_0020, 32'hFFFF_FFFF, 1'b0, 32'h0},
            '{1'b0, 4'hF, 32'h0000_0020, 32'h0,         1'b0, 32'h1122_3344},
            '{1'b1, 4'hF, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 32'h0},
            '{1'b0, 4'hF, 32'h0000_0FFC, 32'h0,         1'b0, 32'hCAFE_F00D},
            '{1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0}
        };
        pat = '{1, 1, 0, 1, 1, 0};

        // Reset state, with requests held high to prove the grant is masked
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            req[k] = 1'b1; we[k] = 1'b0; be[k] = 4'hF; addr[k] = 32'h0;
            wdata[k] = 32'h0; stall[k] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("reset gnt%0d", k), 32'(gnt[k]), 32'd0);
            chk($sformatf("reset rvalid%0d", k), 32'(rvalid[k]), 32'd0);
            chk($sformatf("reset rdata%0d", k), rdata[k], 32'h0);
            chk($sformatf("reset err%0d", k), 32'(err[k]), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < N; k++) req[k] = 1'b0;

        // Table-driven single transactions on the latency-1 instance
        for (int i = 0; i < 16; i++) begin
            txn(0, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, lat, e, r);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
            chk($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d rdata", i), r, vecs[i].exp_rdata);
        end

        // Read-after-write in consecutive cycles
        req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = 32'h40; wdata[0] = 32'h5A5A_1234;
        @(negedge clk);
        chk("raw write gnt", 32'(gnt[0]), 32'd1);
        @(posedge clk); #1;
        we[0] = 1'b0;
        @(negedge clk);
        chk("raw read gnt", 32'(gnt[0]), 32'd1);
        chk("raw write rvalid", 32'(rvalid[0]), 32'd1);
        chk("raw write rdata", rdata[0], 32'h0);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk);
        chk("raw read rvalid", 32'(rvalid[0]), 32'd1);
        chk("raw read rdata", rdata[0], 32'h5A5A_1234);
        @(posedge clk); #1;

        // Stall injection in cycles 2..4 with continuous reads
        grants = 0; rvs = 0; prev_g = 1'b0;
        req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h10;
        for (int c = 0; c < 11; c++) begin
            if (c == 8) req[0] = 1'b0;
            stall[0] = (c >= 2 && c <= 4);
            exp_g = (c < 8) && !(c >= 2 && c <= 4);
            @(negedge clk);
            chk($sformatf("stall gnt c%0d", c), 32'(gnt[0]), 32'(exp_g));
            chk($sformatf("stall rvalid c%0d", c), 32'(rvalid[0]), 32'(prev_g));
            if (gnt[0]) grants++;
            if (rvalid[0]) begin
                rvs++;
                chk($sformatf("stall rdata c%0d", c), rdata[0], 32'hAAAD_55EF);
            end
            prev_g = exp_g;
            @(posedge clk); #1;
        end
        stall[0] = 1'b0;
        chk("stall grant count", 32'(grants), 32'd5);
        chk("stall response count", 32'(rvs), 32'd5);

        // Outstanding limit: latency 3, two outstanding
        for (int i = 0; i < 6; i++) begin
            txn(1, 1'b1, 4'hF, 32'(4 * i), 32'hC0DE_0000 + 32'(i), lat, e, r);
            chk($sformatf("lim prefill%0d latency", i), 32'(lat), 32'd3);
        end
        nidx = 0; rx = 0; first_rv = -1;
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h0;
        for (int c = 0; c < 40 && rx < 6; c++) begin
            @(negedge clk);
            if (c < 6) chk($sformatf("lim gnt c%0d", c), 32'(gnt[1]), 32'(pat[c]));
            if (rvalid[1]) begin
                if (first_rv < 0) first_rv = c;
                chk($sformatf("lim rdata%0d", rx), rdata[1], 32'hC0DE_0000 + 32'(rx));
                rx++;
            end
            if (gnt[1]) nidx++;
            @(posedge clk); #1;
            if (nidx >= 6) req[1] = 1'b0;
            else addr[1] = 32'(4 * nidx);
        end
        req[1] = 1'b0;
        chk("lim responses", 32'(rx), 32'd6);
        chk("lim first rvalid cycle", 32'(first_rv), 32'd3);

        // Reset mid-flight on the latency-4 instance
        txn(2, 1'b1, 4'hF, 32'h1000, 32'h7766_5544, lat, e, r);
        chk("rst prefill latency", 32'(lat), 32'd4);
        req[2] = 1'b1; we[2] = 1'b0; be[2] = 4'hF; addr[2] = 32'h1000;
        @(negedge clk);
        chk("rst pre gnt0", 32'(gnt[2]), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst pre gnt1", 32'(gnt[2]), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst gnt during reset", 32'(gnt[2]), 32'd0);
        chk("rst rvalid during reset", 32'(rvalid[2]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rvs = 0; first_rv = -1;
        for (int c = 0; c < 12; c++) begin
            if (c == 2) req[2] = 1'b0;
            @(negedge clk);
            if (c < 2) chk($sformatf("rst post gnt%0d", c), 32'(gnt[2]), 32'd1);
            if (rvalid[2]) begin
                if (first_rv < 0) first_rv = c;
                rvs++;
                chk($sformatf("rst post rdata%0d", rvs), rdata[2], 32'h7766_5544);
            end
            @(posedge clk); #1;
        end
        chk("rst responses after reset", 32'(rvs), 32'd2);
        chk("rst first rvalid cycle", 32'(first_rv), 32'd4);

        // Memory contents survive reset
        txn(0, 1'b0, 4'hF, 32'h10, 32'h0, lat, e, r);
        chk("persist inst0 rdata", r, 32'hAAAD_55EF);
        txn(2, 1'b0, 4'hF, 32'h1000, 32'h0, lat, e, r);
        chk("persist inst2 rdata", r, 32'h7766_5544);
        txn(2, 1'b0, 4'hF, 32'h0FFC, 32'h0, lat, e, r);
        chk("below base err", 32'(e), 32'd1);

        // Randomised traffic
        rand_run(0, 400);
        rand_run(2, 400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
